// File: rtl/param_proc_ctrl.sv
// Multicycle fetch/decode/execute controller for the 16-bit processor.
// Owns PC and IR; every datapath control is decoded from State and IR.
module param_proc_ctrl #(
  parameter int PC_WIDTH     = 7,
  parameter int D_ADDR_WIDTH = 8
) (
  input  logic                    Clock,
  input  logic                    Reset,
  output logic                    IM_Req,
  output logic [PC_WIDTH-1:0]     IM_Addr,
  input  logic                    IM_Ready,
  input  logic [15:0]             IM_Data,
  input  logic                    Zero_Flag,
  output logic [15:0]             IR,
  output logic [PC_WIDTH-1:0]     PC_Out,
  output logic [3:0]              State,
  output logic [3:0]              NextState,
  output logic [D_ADDR_WIDTH-1:0] D_addr,
  output logic                    D_wr,
  output logic [1:0]              RF_s,
  output logic [3:0]              RF_W_addr,
  output logic                    RF_W_en,
  output logic [3:0]              RF_Ra_addr,
  output logic [3:0]              RF_Rb_addr,
  output logic [2:0]              Alu_s0,
  output logic [7:0]              Imm_Out,
  output logic                    Illegal,
  output logic                    Halted
);

  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_LOAD_A = 4'd3;
  localparam logic [3:0] S_LOAD_B = 4'd4;
  localparam logic [3:0] S_STORE  = 4'd5;
  localparam logic [3:0] S_ADD    = 4'd6;
  localparam logic [3:0] S_SUB    = 4'd7;
  localparam logic [3:0] S_LDI    = 4'd8;
  localparam logic [3:0] S_JMP    = 4'd9;
  localparam logic [3:0] S_JZ     = 4'd10;
  localparam logic [3:0] S_HALT   = 4'd11;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_LDI   = 4'd6;
  localparam logic [3:0] OP_JMP   = 4'd7;
  localparam logic [3:0] OP_JZ    = 4'd8;

  localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  logic [3:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         ir_q, ir_d;
  logic [PC_WIDTH-1:0] jz_target_s;

  // JZ target is the 8-bit field zero-extended, or truncated for narrow PCs
  always_comb begin
    jz_target_s = '0;
    for (int i = 0; i < PC_WIDTH && i < 8; i++) begin
      jz_target_s[i] = ir_q[i];
    end
  end

  // Next-state, PC and IR update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_INIT: state_d = S_FETCH;
      S_FETCH: begin
        if (IM_Ready) begin
          ir_d    = IM_Data;
          pc_d    = pc_q + PC_ONE;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (ir_q[15:12])
          OP_NOOP:  state_d = S_FETCH;
          OP_STORE: state_d = S_STORE;
          OP_LOAD:  state_d = S_LOAD_A;
          OP_ADD:   state_d = S_ADD;
          OP_SUB:   state_d = S_SUB;
          OP_HALT:  state_d = S_HALT;
          OP_LDI:   state_d = S_LDI;
          OP_JMP:   state_d = S_JMP;
          OP_JZ:    state_d = S_JZ;
          default:  state_d = S_FETCH;
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B, S_STORE, S_ADD, S_SUB, S_LDI: state_d = S_FETCH;
      // Jump targets replace the PC that FETCH already incremented
      S_JMP: begin
        pc_d    = ir_q[PC_WIDTH-1:0];
        state_d = S_FETCH;
      end
      S_JZ: begin
        if (Zero_Flag) begin
          pc_d = jz_target_s;
        end else begin
          pc_d = pc_q;
        end
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_INIT;
    endcase
  end

  // Moore control decode from state and IR
  always_comb begin
    IM_Req     = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = 2'd0;
    RF_W_addr  = 4'd0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = 4'd0;
    RF_Rb_addr = 4'd0;
    Alu_s0     = 3'd0;
    Illegal    = 1'b0;
    Halted     = 1'b0;
    case (state_q)
      S_FETCH: IM_Req = 1'b1;
      S_DECODE: begin
        if (ir_q[15:12] > OP_JZ) begin
          Illegal = 1'b1;
        end else begin
          Illegal = 1'b0;
        end
      end
      S_STORE: begin
        D_addr     = ir_q[4 +: D_ADDR_WIDTH];
        RF_Ra_addr = ir_q[3:0];
        D_wr       = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        D_addr    = ir_q[4 +: D_ADDR_WIDTH];
        RF_s      = 2'd1;
        RF_W_addr = ir_q[3:0];
        RF_W_en   = (state_q == S_LOAD_B);
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ir_q[11:8];
        RF_Rb_addr = ir_q[7:4];
        RF_W_addr  = ir_q[3:0];
        RF_W_en    = 1'b1;
        Alu_s0     = (state_q == S_ADD) ? 3'd1 : 3'd2;
      end
      S_LDI: begin
        RF_s      = 2'd2;
        RF_W_addr = ir_q[3:0];
        RF_W_en   = 1'b1;
      end
      S_JZ:    RF_Ra_addr = ir_q[11:8];
      S_HALT:  Halted = 1'b1;
      default: Halted = 1'b0;
    endcase
  end

  // State, PC and IR registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_INIT;
      pc_q    <= '0;
      ir_q    <= 16'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  assign IM_Addr   = pc_q;
  assign PC_Out    = pc_q;
  assign IR        = ir_q;
  assign State     = state_q;
  assign NextState = state_d;
  assign Imm_Out   = ir_q[11:4];

endmodule

// File: tb/tb_param_proc_ctrl.sv
// Self-checking bench for param_proc_ctrl: directed programs plus random
// instruction streams checked against an instruction-level model.
module tb_param_proc_ctrl;
  localparam int PCW = 7;
  localparam int DAW = 8;

  logic           Clock = 1'b0;
  logic           Reset;
  logic           IM_Req;
  logic [PCW-1:0] IM_Addr;
  logic           IM_Ready;
  logic [15:0]    IM_Data;
  logic           Zero_Flag;
  logic [15:0]    IR;
  logic [PCW-1:0] PC_Out;
  logic [3:0]     State, NextState;
  logic [DAW-1:0] D_addr;
  logic           D_wr;
  logic [1:0]     RF_s;
  logic [3:0]     RF_W_addr;
  logic           RF_W_en;
  logic [3:0]     RF_Ra_addr, RF_Rb_addr;
  logic [2:0]     Alu_s0;
  logic [7:0]     Imm_Out;
  logic           Illegal, Halted;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  logic [PCW-1:0] m_pc;
  logic [15:0]    m_ir;

  param_proc_ctrl #(.PC_WIDTH(PCW), .D_ADDR_WIDTH(DAW)) dut (
    .Clock(Clock), .Reset(Reset), .IM_Req(IM_Req), .IM_Addr(IM_Addr),
    .IM_Ready(IM_Ready), .IM_Data(IM_Data), .Zero_Flag(Zero_Flag), .IR(IR),
    .PC_Out(PC_Out), .State(State), .NextState(NextState), .D_addr(D_addr),
    .D_wr(D_wr), .RF_s(RF_s), .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en),
    .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .Alu_s0(Alu_s0),
    .Imm_Out(Imm_Out), .Illegal(Illegal), .Halted(Halted)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic logic [37:0] obs();
    return {IM_Req, D_wr, RF_W_en, Illegal, Halted, State, NextState, D_addr,
            RF_s, RF_W_addr, RF_Ra_addr, RF_Rb_addr, Alu_s0};
  endfunction

  function automatic logic [37:0] regs();
    return {IM_Addr, PC_Out, IR, Imm_Out};
  endfunction

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Applies reset, checks the reset state, releases, ends in FETCH at PC 0.
  task automatic do_reset();
    logic [37:0] e;
    Reset = 1'b0;
    IM_Ready = 1'b0;
    #1;
    e = {5'b00000, 4'd0, 4'd1, 25'd0};
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL reset_ctl: got %h want %h", obs(), e);
    end
    n_tests++;
    if (regs() !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_regs: got %h want 0", regs());
    end
    step();
    Reset = 1'b1;
    #1;
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL init_ctl: got %h want %h", obs(), e);
    end
    t0 = cyc;
    step();
    m_pc = '0;
    m_ir = 16'd0;
  endtask

  // Serves one instruction fetch (with wait states) and checks every cycle
  // up to the next FETCH; for HALT it returns while sitting in HALT.
  task automatic run_instr(input logic [15:0] ins, input int waits, input logic zf);
    logic [3:0]  op, s, nx, ra, rb, wa;
    logic [3:0]  st [0:1];
    logic [7:0]  daddr;
    logic [1:0]  rfs;
    logic [2:0]  alu;
    logic [15:0] tmp;
    logic [37:0] e;
    logic        wen;
    int          n;
    op = ins[15:12];
    st[0] = 4'd1;
    st[1] = 4'd1;
    n = 1;
    case (op)
      4'd1: st[0] = 4'd5;
      4'd2: begin st[0] = 4'd3; st[1] = 4'd4; n = 2; end
      4'd3: st[0] = 4'd6;
      4'd4: st[0] = 4'd7;
      4'd5: st[0] = 4'd11;
      4'd6: st[0] = 4'd8;
      4'd7: st[0] = 4'd9;
      4'd8: st[0] = 4'd10;
      default: n = 0;
    endcase
    daddr = (op == 4'd1 || op == 4'd2) ? ins[11:4] : 8'd0;
    rfs   = (op == 4'd2) ? 2'd1 : ((op == 4'd6) ? 2'd2 : 2'd0);
    wa    = (op == 4'd2 || op == 4'd3 || op == 4'd4 || op == 4'd6) ? ins[3:0] : 4'd0;
    ra    = (op == 4'd1) ? ins[3:0] : ((op == 4'd3 || op == 4'd4 || op == 4'd8) ? ins[11:8] : 4'd0);
    rb    = (op == 4'd3 || op == 4'd4) ? ins[7:4] : 4'd0;
    alu   = (op == 4'd3) ? 3'd1 : ((op == 4'd4) ? 3'd2 : 3'd0);

    for (int w = 0; w <= waits; w++) begin
      IM_Ready  = (w == waits);
      IM_Data   = (w == waits) ? ins : 16'($urandom);
      Zero_Flag = 1'($urandom);
      #1;
      e = {1'b1, 4'b0000, 4'd1, ((w == waits) ? 4'd2 : 4'd1), 25'd0};
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL fetch_ctl ins=%h w=%0d: got %h want %h", ins, w, obs(), e);
      end
      n_tests++;
      if (regs() !== {m_pc, m_pc, m_ir, m_ir[11:4]}) begin
        n_fail++;
        $display("FAIL fetch_regs ins=%h: got %h want %h", ins, regs(), {m_pc, m_pc, m_ir, m_ir[11:4]});
      end
      step();
    end

    m_ir = ins;
    m_pc = m_pc + 1'b1;
    IM_Ready  = 1'($urandom);
    IM_Data   = 16'($urandom);
    Zero_Flag = zf;
    #1;
    e = {3'b000, (op > 4'd8), 1'b0, 4'd2, st[0], 25'd0};
    n_tests++;
    if (obs() !== e) begin
      n_fail++;
      $display("FAIL decode_ctl ins=%h: got %h want %h", ins, obs(), e);
    end
    n_tests++;
    if (regs() !== {m_pc, m_pc, m_ir, m_ir[11:4]}) begin
      n_fail++;
      $display("FAIL decode_regs ins=%h: got %h want %h", ins, regs(), {m_pc, m_pc, m_ir, m_ir[11:4]});
    end

    for (int k = 0; k < n; k++) begin
      step();
      IM_Ready = 1'($urandom);
      #1;
      s   = st[k];
      nx  = (k + 1 < n) ? st[k+1] : ((op == 4'd5) ? 4'd11 : 4'd1);
      wen = (op == 4'd3 || op == 4'd4 || op == 4'd6 || (op == 4'd2 && k == 1));
      e = {1'b0, (op == 4'd1), wen, 1'b0, (op == 4'd5), s, nx, daddr, rfs, wa, ra, rb, alu};
      n_tests++;
      if (obs() !== e) begin
        n_fail++;
        $display("FAIL exec_ctl ins=%h k=%0d: got %h want %h", ins, k, obs(), e);
      end
      n_tests++;
      if (regs() !== {m_pc, m_pc, m_ir, m_ir[11:4]}) begin
        n_fail++;
        $display("FAIL exec_regs ins=%h: got %h want %h", ins, regs(), {m_pc, m_pc, m_ir, m_ir[11:4]});
      end
    end

    if (op == 4'd7) begin
      m_pc = ins[PCW-1:0];
    end else if (op == 4'd8 && zf) begin
      tmp  = {8'd0, ins[7:0]};
      m_pc = tmp[PCW-1:0];
    end
    if (op != 4'd5) begin
      step();
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    IM_Ready = 1'b0;
    IM_Data = 16'd0;
    Zero_Flag = 1'b0;
    step();
    do_reset();
    run_instr(16'h6A53, 0, 1'b0);
    // Pull reset mid-cycle while FETCH is requesting
    IM_Ready = 1'b0;
    #2;
    Reset = 1'b0;
    #1;
    n_tests++;
    if ({IM_Req, State, PC_Out, IR} !== 28'd0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0", {IM_Req, State, PC_Out, IR});
    end
    step();
    Reset = 1'b1;
    #1;
    n_tests++;
    if (State !== 4'd0) begin
      n_fail++;
      $display("FAIL post_reset_init: got %0d want 0", State);
    end
    step();
    n_tests++;
    if ({State, IM_Req, IM_Addr} !== {4'd1, 1'b1, 7'd0}) begin
      n_fail++;
      $display("FAIL post_reset_fetch: got %h want %h", {State, IM_Req, IM_Addr}, {4'd1, 1'b1, 7'd0});
    end
    m_pc = '0;
    m_ir = 16'd0;
  endtask

  task automatic test_program();
    do_reset();
    run_instr(16'h6A53, 0, 1'b0);
    run_instr(16'h1203, 0, 1'b0);
    run_instr(16'h5000, 0, 1'b0);
    n_tests++;
    if ({cyc - t0, 1'b0 + Halted, PC_Out} !== {32'd9, 1'b1, 7'd3}) begin
      n_fail++;
      $display("FAIL halt_timing: got cyc=%0d halted=%0b pc=%0d want 9 1 3", cyc - t0, Halted, PC_Out);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      IM_Ready = 1'b1;
      #1;
      n_tests++;
      if ({State, Halted, IM_Req, D_wr, RF_W_en, PC_Out} !== {4'd11, 4'b1000, 7'd3}) begin
        n_fail++;
        $display("FAIL halt_hold: got %h want %h", {State, Halted, IM_Req, D_wr, RF_W_en, PC_Out}, {4'd11, 4'b1000, 7'd3});
      end
    end
  endtask

  task automatic test_wait_states();
    do_reset();
    run_instr(16'h0000, 3, 1'b0);
    n_tests++;
    if (PC_Out !== 7'd1) begin
      n_fail++;
      $display("FAIL wait_pc: got %0d want 1", PC_Out);
    end
    run_instr(16'h6123, 2, 1'b1);
  endtask

  task automatic test_load_add();
    do_reset();
    run_instr(16'h2104, 0, 1'b0);
    run_instr(16'h3124, 1, 1'b0);
    run_instr(16'h4FE1, 0, 1'b1);
  endtask

  task automatic test_jumps();
    do_reset();
    run_instr(16'h8305, 1, 1'b1);
    n_tests++;
    if (IM_Addr !== 7'd5) begin
      n_fail++;
      $display("FAIL jz_taken: got %0d want 5", IM_Addr);
    end
    run_instr(16'h8305, 0, 1'b0);
    n_tests++;
    if (IM_Addr !== 7'd6) begin
      n_fail++;
      $display("FAIL jz_not_taken: got %0d want 6", IM_Addr);
    end
    run_instr(16'h707F, 0, 1'b0);
    n_tests++;
    if (PC_Out !== 7'h7F) begin
      n_fail++;
      $display("FAIL jmp_target: got %h want 7f", PC_Out);
    end
    run_instr(16'h0000, 2, 1'b0);
    n_tests++;
    if (PC_Out !== 7'd0) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h want 0", PC_Out);
    end
    run_instr(16'h7000, 0, 1'b0);
    n_tests++;
    if (IM_Addr !== 7'd0) begin
      n_fail++;
      $display("FAIL tight_loop: got %h want 0", IM_Addr);
    end
    run_instr(16'h80FF, 0, 1'b1);
  endtask

  task automatic test_illegal();
    do_reset();
    run_instr(16'hB000, 0, 1'b0);
    for (int op = 9; op < 16; op++) begin
      run_instr({4'(op), 12'($urandom)}, 0, 1'($urandom));
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    do_reset();
    for (int i = 0; i < 60; i++) begin
      ins = 16'($urandom);
      run_instr(ins, int'($urandom_range(0, 3)), 1'($urandom));
      if (ins[15:12] == 4'd5) begin
        do_reset();
      end
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_wait_states();
    test_load_add();
    test_jumps();
    test_illegal();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_proc_ctrl.md
Name: param_proc_ctrl

Overview:
- Parametrised multicycle control unit for the 16-bit processor.
- Sequences fetch/decode/execute, owns PC and IR, and drives register-file, data-memory and ALU controls into the existing datapath.
- Adds over the previous generation:
  - parametrised PC and data-address widths;
  - ready/valid instruction-memory handshake with wait states;
  - load-immediate, jump and jump-if-zero instructions;
  - illegal-opcode flagging;
  - a halted status output.

Parameters:
- PC_WIDTH, 7, program-counter/instruction-address width (legal range 4..12).
- D_ADDR_WIDTH, 8, data-memory address width (legal range 1..8; taken from IR LSBs of the 8-bit address field).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- IM_Req  out  1  instruction fetch request.
- IM_Addr  out  PC_WIDTH  fetch address (= PC).
- IM_Ready  in  1  instruction word valid this cycle.
- IM_Data  in  16  instruction word.
- Zero_Flag  in  1  datapath flag, high when RF[Ra] == 0.
- IR  out  16  instruction register.
- PC_Out  out  PC_WIDTH  program counter.
- State  out  4  current state.
- NextState  out  4  combinational next state.
- D_addr  out  D_ADDR_WIDTH  data-memory address.
- D_wr  out  1  data-memory write enable.
- RF_s  out  2  RF write-data select: 0 = ALU, 1 = memory, 2 = immediate.
- RF_W_addr  out  4  RF write address.
- RF_W_en  out  1  RF write enable.
- RF_Ra_addr  out  4  RF read port A address.
- RF_Rb_addr  out  4  RF read port B address.
- Alu_s0  out  3  ALU op: 0 = pass/none, 1 = add, 2 = sub.
- Imm_Out  out  8  immediate value, IR[11:4].
- Illegal  out  1  one-cycle pulse in DECODE for an unknown opcode.
- Halted  out  1  high while in HALT.

Behaviour:
- Reset (Reset low, asynchronous):
  - State = INIT, PC = 0, IR = 0.
  - All enables (IM_Req, D_wr, RF_W_en), Illegal and Halted = 0.
  - Address/select outputs = 0.
  - Takes effect mid-fetch or mid-execute with no completion of the pending operation.
- Control outputs are Moore-decoded from State and IR (combinational). Only State, PC and IR are registers.
- State encoding: INIT 0, FETCH 1, DECODE 2, LOAD_A 3, LOAD_B 4, STORE 5, ADD 6, SUB 7, LDI 8, JMP 9, JZ 10, HALT 11.
- INIT -> FETCH unconditionally.
- FETCH:
  - IM_Req = 1, IM_Addr = PC.
  - Stay in FETCH while IM_Ready = 0.
  - On a clock edge with IM_Ready = 1: IR <= IM_Data, PC <= PC+1 (wraps 2^PC_WIDTH-1 -> 0), go to DECODE.
  - Minimum fetch latency is 1 cycle; each wait cycle adds 1.
- DECODE on IR[15:12]:
  - 0 NOOP -> FETCH
  - 1 STORE -> STORE
  - 2 LOAD -> LOAD_A
  - 3 ADD -> ADD
  - 4 SUB -> SUB
  - 5 HALT -> HALT
  - 6 LDI -> LDI
  - 7 JMP -> JMP
  - 8 JZ -> JZ
  - 9..F -> FETCH with Illegal = 1 for the DECODE cycle (treated as NOOP).
- Field use:
  - STORE: D_addr = IR[11:4] (low D_ADDR_WIDTH bits), Ra = IR[3:0], D_wr = 1 for one cycle -> FETCH.
  - LOAD_A: D_addr = IR[11:4], RF_s = 1, RF_W_addr = IR[3:0], RF_W_en = 0 -> LOAD_B.
  - LOAD_B: same drives with RF_W_en = 1 -> FETCH. Total 2 execute cycles.
  - ADD/SUB: Ra = IR[11:8], Rb = IR[7:4], RF_W_addr = IR[3:0], RF_s = 0, Alu_s0 = 1/2, RF_W_en = 1 -> FETCH.
  - LDI: RF_s = 2, Imm_Out = IR[11:4], RF_W_addr = IR[3:0], RF_W_en = 1 -> FETCH.
  - JMP: PC <= IR[PC_WIDTH-1:0] -> FETCH.
  - JZ: Ra = IR[11:8]. If Zero_Flag = 1, PC <= {0, IR[7:0]} truncated/zero-extended to PC_WIDTH; otherwise PC unchanged -> FETCH.
- Jump targets override the already-incremented PC. A jump to the current PC is a legal tight loop.
- HALT: Halted = 1, all enables 0, IM_Req = 0. Stays in HALT until Reset; IM_Ready is ignored.
- In non-FETCH states IM_Req = 0 and IM_Ready is ignored.
- Imm_Out always reflects IR[11:4] irrespective of state.

Test Plan:
- Reset low mid-FETCH with IM_Req = 1 -> IM_Req, State, PC and IR all 0 immediately (same cycle). Release -> INIT, then FETCH at PC = 0.
- Program {0x6A53 LDI R3 <- 0xA5, 0x1203 STORE R3 -> [0x20], 0x5000 HALT} with IM_Ready always 1:
  - LDI drives RF_s = 2, Imm_Out = 0xA5, RF_W_en = 1.
  - STORE drives D_wr = 1 with D_addr = 0x20, RF_Ra_addr = 3.
  - Halted = 1 by cycle 9 after INIT; PC = 3.
- IM_Ready held low 3 cycles during the first fetch -> State stays 1 for 4 cycles, PC stays 0, IR updates only on the ready edge.
- 0x2104 LOAD -> LOAD_A (RF_W_en = 0) then LOAD_B (RF_W_en = 1), D_addr = 0x10, RF_W_addr = 4, RF_s = 1. 0x3124 ADD -> Ra = 1, Rb = 2, W = 4, Alu_s0 = 1.
- 0x8305 JZ R3 -> 5:
  - Zero_Flag = 1 -> next fetch address 5.
  - Zero_Flag = 0 -> next fetch address PC+1.
  - 0x707F JMP with PC_WIDTH = 7 -> PC = 0x7F.
  - Fetch at 0x7F -> PC wraps to 0.
- 0xB000 -> Illegal pulses exactly one cycle in DECODE, no enables asserted, next state FETCH.
